// File: rtl/pulse_out_monitor_pkg.sv
`default_nettype none
//============================================================================
// pulse_mon_pkg - state encoding and pulser timing constants for pulse_out_monitor
// Rev 1.0
//============================================================================
package pulse_mon_pkg;

   localparam logic [1:0] c_ST_IDLE      = 2'd0;
   localparam logic [1:0] c_ST_WAIT_RISE = 2'd1;
   localparam logic [1:0] c_ST_MEASURE   = 2'd2;
   localparam logic [1:0] c_ST_WAIT_LOW  = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = c_ST_IDLE,
      WAIT_RISE = c_ST_WAIT_RISE,
      MEASURE   = c_ST_MEASURE,
      WAIT_LOW  = c_ST_WAIT_LOW
   } mon_state_e;

   // Nominal pulser timing, shared with the pulser block
   localparam int c_PULSER_NOM_HIGH = 3;
   localparam int c_PULSER_PERIOD   = 2400;

endpackage
`default_nettype wire

// File: rtl/pulse_out_monitor_if.sv
`default_nettype none
//============================================================================
// pulse_out_monitor_if - command/sense/status bundle between pulser top and monitor
// Rev 1.0  (Width_Min_Seen/Width_Max_Seen present only with PULSE_MON_STATS_EN)
//============================================================================
interface pulse_out_monitor_if #(
   parameter int CNT_W = 12
);
   logic             Pulse_Control_In;
   logic             Out_Pulse_Measure;
   logic             Reset_All_Errors;
   logic             Pulse_Seen;
   logic [CNT_W-1:0] Pulse_Width_Meas;
   logic [15:0]      Pulse_Count;
   logic             No_Response_Error;
   logic             Width_Error;
   logic             Spurious_Error;
   logic             Rate_Error;
   logic             Monitor_Error_Any;
`ifdef PULSE_MON_STATS_EN
   logic [CNT_W-1:0] Width_Min_Seen;
   logic [CNT_W-1:0] Width_Max_Seen;
`endif

   modport master (
`ifdef PULSE_MON_STATS_EN
      input  Width_Min_Seen, Width_Max_Seen,
`endif
      output Pulse_Control_In, Out_Pulse_Measure, Reset_All_Errors,
      input  Pulse_Seen, Pulse_Width_Meas, Pulse_Count,
      input  No_Response_Error, Width_Error, Spurious_Error, Rate_Error, Monitor_Error_Any
   );

   modport slave (
`ifdef PULSE_MON_STATS_EN
      output Width_Min_Seen, Width_Max_Seen,
`endif
      input  Pulse_Control_In, Out_Pulse_Measure, Reset_All_Errors,
      output Pulse_Seen, Pulse_Width_Meas, Pulse_Count,
      output No_Response_Error, Width_Error, Spurious_Error, Rate_Error, Monitor_Error_Any
   );

endinterface
`default_nettype wire

// File: rtl/pulse_out_monitor_sync_edge.sv
`default_nettype none
//============================================================================
// pulse_sync_edge - N-stage synchronizer with registered rise/fall strobes
// Rev 1.0
//============================================================================
module pulse_sync_edge #(
   parameter int STAGES = 2
) (
   input  wire logic clk,
   input  wire logic reset_n,
   input  wire logic i_async,
   output logic      o_level,
   output logic      o_rise,
   output logic      o_fall
);

   logic [STAGES-1:0] r_sync;
   logic [STAGES:0]   r_vld;
   logic              r_level;
   logic              r_rise;
   logic              r_fall;

   // r_vld tracks which stages hold real samples since reset, so a level that
   // was already high at reset release never produces an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync  <= '0;
         r_vld   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[STAGES-2:0], i_async};
         r_vld   <= {r_vld[STAGES-1:0], 1'b1};
         r_level <= r_sync[STAGES-1];
         r_rise  <= r_vld[STAGES] &  r_sync[STAGES-1] & ~r_level;
         r_fall  <= r_vld[STAGES] & ~r_sync[STAGES-1] &  r_level;
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/pulse_out_monitor.sv
`default_nettype none
//============================================================================
// pulse_out_monitor - checks pulser command against sensed output pulse, measures
// width/spacing, raises sticky errors. Rev 1.0  (optional stats: PULSE_MON_STATS_EN)
//============================================================================
module pulse_out_monitor
   import pulse_mon_pkg::*;
#(
   parameter int CNT_W        = 12,
   parameter int RESP_TIMEOUT = 8,
   parameter int WIDTH_MIN    = 2,
   parameter int WIDTH_MAX    = 5,
   parameter int MIN_GAP      = 2400
) (
   input  wire logic          clk,
   input  wire logic          reset_n,
   pulse_out_monitor_if.slave bus
);

   localparam logic [CNT_W-1:0] c_CNT_MAX      = '1;
   localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(RESP_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] c_WMIN         = CNT_W'(WIDTH_MIN);
   localparam logic [CNT_W-1:0] c_WMAX         = CNT_W'(WIDTH_MAX);
   localparam logic [CNT_W-1:0] c_WOVER        = CNT_W'(WIDTH_MAX + 1);
   // Gap counter reads D-1 at a rise D cycles after the previous one
   localparam logic [CNT_W-1:0] c_GAP_LIM      = CNT_W'(MIN_GAP - 1);

   logic             w_sense_lvl;
   logic             w_sense_rise;
   logic             w_sense_fall;
   logic             w_cmd_rise;

   mon_state_e       r_state;
   logic             r_cmd_prev;
   logic [CNT_W-1:0] r_timer;
   logic [CNT_W-1:0] r_width;
   logic [CNT_W-1:0] r_gap;
   logic             r_first_seen;
   logic             r_pulse_seen;
   logic [CNT_W-1:0] r_width_meas;
   logic [15:0]      r_pulse_count;
   logic             r_err_noresp;
   logic             r_err_width;
   logic             r_err_spur;
   logic             r_err_rate;
   logic             r_err_any;

   pulse_sync_edge #(.STAGES(2)) u_sense_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_async (bus.Out_Pulse_Measure),
      .o_level (w_sense_lvl),
      .o_rise  (w_sense_rise),
      .o_fall  (w_sense_fall)
   );

   assign w_cmd_rise = bus.Pulse_Control_In & ~r_cmd_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_cmd_prev    <= 1'b0;
         r_timer       <= '0;
         r_width       <= '0;
         r_gap         <= '0;
         r_first_seen  <= 1'b0;
         r_pulse_seen  <= 1'b0;
         r_width_meas  <= '0;
         r_pulse_count <= '0;
         r_err_noresp  <= 1'b0;
         r_err_width   <= 1'b0;
         r_err_spur    <= 1'b0;
         r_err_rate    <= 1'b0;
         r_err_any     <= 1'b0;
      end else begin
         r_cmd_prev   <= bus.Pulse_Control_In;
         r_pulse_seen <= 1'b0;
         r_err_any    <= r_err_noresp | r_err_width | r_err_spur | r_err_rate;

         // Clear first; any set further down overrides it in the same cycle
         if (bus.Reset_All_Errors) begin
            r_err_noresp <= 1'b0;
            r_err_width  <= 1'b0;
            r_err_spur   <= 1'b0;
            r_err_rate   <= 1'b0;
         end

         if (w_sense_rise) begin
            if (r_first_seen && (r_gap < c_GAP_LIM))
               r_err_rate <= 1'b1;
            r_gap        <= '0;
            r_first_seen <= 1'b1;
         end else if (r_gap != c_CNT_MAX) begin
            r_gap <= r_gap + 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (w_sense_rise) begin
                  if (w_cmd_rise) begin
                     r_state <= MEASURE;
                     r_width <= CNT_W'(1);
                  end else begin
                     r_err_spur <= 1'b1;
                     r_state    <= WAIT_LOW;
                  end
               end else if (w_cmd_rise) begin
                  r_state <= WAIT_RISE;
                  r_timer <= '0;
               end
            end
            WAIT_RISE: begin
               if (w_sense_rise) begin
                  r_state <= MEASURE;
                  r_width <= CNT_W'(1);
               end else if (r_timer == c_TIMEOUT_LAST) begin
                  r_err_noresp <= 1'b1;
                  r_state      <= IDLE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            MEASURE: begin
               if (w_sense_fall) begin
                  r_width_meas  <= r_width;
                  r_pulse_seen  <= 1'b1;
                  r_pulse_count <= r_pulse_count + 16'd1;
                  if (r_width < c_WMIN)
                     r_err_width <= 1'b1;
                  r_state <= IDLE;
               end else if (w_sense_lvl) begin
                  if (r_width >= c_WMAX) begin
                     r_err_width  <= 1'b1;
                     r_width_meas <= c_WOVER;
                     r_state      <= WAIT_LOW;
                  end else if (r_width != c_CNT_MAX) begin
                     r_width <= r_width + 1'b1;
                  end
               end
            end
            WAIT_LOW: begin
               if (!w_sense_lvl)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.Pulse_Seen        = r_pulse_seen;
   assign bus.Pulse_Width_Meas  = r_width_meas;
   assign bus.Pulse_Count       = r_pulse_count;
   assign bus.No_Response_Error = r_err_noresp;
   assign bus.Width_Error       = r_err_width;
   assign bus.Spurious_Error    = r_err_spur;
   assign bus.Rate_Error        = r_err_rate;
   assign bus.Monitor_Error_Any = r_err_any;

`ifdef PULSE_MON_STATS_EN
   logic             w_meas_done;
   logic [CNT_W-1:0] r_wmin;
   logic [CNT_W-1:0] r_wmax;

   assign w_meas_done = (r_state == MEASURE) && w_sense_fall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wmin <= '1;
         r_wmax <= '0;
      end else if (bus.Reset_All_Errors) begin
         r_wmin <= '1;
         r_wmax <= '0;
      end else if (w_meas_done) begin
         if (r_width < r_wmin)
            r_wmin <= r_width;
         if (r_width > r_wmax)
            r_wmax <= r_width;
      end
   end

   assign bus.Width_Min_Seen = r_wmin;
   assign bus.Width_Max_Seen = r_wmax;
`endif

endmodule
`default_nettype wire
